ifu_fetch_ctrl: RTL and testbench



---
 rtl/ifu_fetch_ctrl.sv | 149 ++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the IM word index and queues {pc, instr} pairs for decode.
// Optional FETCH_PERF_EN adds fetch and decode-stall event counters.
module ifu_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
    localparam logic [32:0] IM_HI = IM_LO + 33'(IM_WORDS) * 33'd4;

    typedef enum logic {S_FETCH, S_HALT} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fpc_q, fpc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     pc_mem    [QDEPTH];
    logic [31:0]     instr_mem [QDEPTH];

    logic        pc_ok, enq, deq;
    logic [31:0] offset;
    logic        unused_offset_bits;

    assign offset             = fpc_q - IM_BASE;
    assign unused_offset_bits = ^{offset[31:14], offset[1:0]};
    assign pc_ok   = (fpc_q[1:0] == 2'b00) && ({1'b0, fpc_q} >= IM_LO) && ({1'b0, fpc_q} < IM_HI);
    assign im_addr = pc_ok ? offset[13:2] : 12'd0;

    assign out_valid = (count_q != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : 32'd0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : 32'd0;

    assign deq = out_valid && out_ready;
    // A full queue may still accept a push when the head leaves in the same cycle.
    assign enq = (state_q == S_FETCH) && pc_ok && !redirect_valid &&
                 ((count_q < CW'(QDEPTH)) || deq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
        end else if (state_q == S_FETCH && !pc_ok) begin
            state_d = S_HALT;
        end
    end

    always_comb begin
        fetch_fault = (state_q == S_HALT);
    end

    always_comb begin
        fpc_d    = fpc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            // Flush drops everything, including an entry being dequeued this cycle.
            fpc_d    = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq) begin
                fpc_d    = fpc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q    <= PC_RESET;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            fpc_q    <= fpc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset: the head outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr_q]    <= fpc_q;
            instr_mem[wr_ptr_q] <= im_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (enq) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: a vector table for the main flow plus a hand sequence for async reset.
module tb_ifu_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    logic [31:0] im_mem [4096];
    assign im_rdata = im_mem[im_addr];

    always #5 clk = ~clk;

    ifu_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .im_addr        (im_addr),
        .im_rdata       (im_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs applied in the cycle, and outputs expected during that same cycle.
    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic        ef;
        logic [11:0] ea;
    } vec_t;

    function automatic vec_t mk(logic rv, logic [31:0] rpc, logic rdy, logic ev,
                                logic [31:0] epc, logic [31:0] ei, logic ef, logic [11:0] ea);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.epc = epc; v.ei = ei; v.ef = ef; v.ea = ea;
        return v;
    endfunction

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        for (int i = 0; i < 4096; i++) im_mem[i] = 32'hC000_0000 | i;
        im_mem[0] = 32'h1111_1111;
        im_mem[1] = 32'h2222_2222;
        im_mem[2] = 32'h3333_3333;
        im_mem[3] = 32'h4444_4444;

        //            rv  rpc           rdy  ev  pc            instr          f   addr
        vecs[0]  = mk(0, 32'h0,         1,   0, 32'h0,        32'h0,         0, 12'h000);
        vecs[1]  = mk(0, 32'h0,         1,   1, 32'h3000,     32'h1111_1111, 0, 12'h001);
        vecs[2]  = mk(0, 32'h0,         1,   1, 32'h3004,     32'h2222_2222, 0, 12'h002);
        vecs[3]  = mk(0, 32'h0,         1,   1, 32'h3008,     32'h3333_3333, 0, 12'h003);
        vecs[4]  = mk(0, 32'h0,         0,   1, 32'h300C,     32'h4444_4444, 0, 12'h004);
        vecs[5]  = mk(0, 32'h0,         0,   1, 32'h300C,     32'h4444_4444, 0, 12'h005);
        vecs[6]  = mk(0, 32'h0,         0,   1, 32'h300C,     32'h4444_4444, 0, 12'h005);
        vecs[7]  = mk(0, 32'h0,         1,   1, 32'h300C,     32'h4444_4444, 0, 12'h005);
        vecs[8]  = mk(0, 32'h0,         1,   1, 32'h3010,     32'hC000_0004, 0, 12'h006);
        vecs[9]  = mk(1, 32'h3100,      0,   1, 32'h3014,     32'hC000_0005, 0, 12'h007);
        vecs[10] = mk(0, 32'h0,         1,   0, 32'h0,        32'h0,         0, 12'h040);
        vecs[11] = mk(1, 32'h3102,      1,   1, 32'h3100,     32'hC000_0040, 0, 12'h041);
        vecs[12] = mk(0, 32'h0,         1,   0, 32'h0,        32'h0,         0, 12'h000);
        vecs[13] = mk(0, 32'h0,         1,   0, 32'h0,        32'h0,         1, 12'h000);
        vecs[14] = mk(1, 32'h6FFC,      1,   0, 32'h0,        32'h0,         1, 12'h000);
        vecs[15] = mk(0, 32'h0,         1,   0, 32'h0,        32'h0,         0, 12'hFFF);
        vecs[16] = mk(0, 32'h0,         1,   1, 32'h6FFC,     32'hC000_0FFF, 0, 12'h000);
        vecs[17] = mk(1, 32'h3000,      1,   0, 32'h0,        32'h0,         1, 12'h000);
        vecs[18] = mk(0, 32'h0,         1,   0, 32'h0,        32'h0,         0, 12'h000);
        vecs[19] = mk(0, 32'h0,         1,   1, 32'h3000,     32'h1111_1111, 0, 12'h001);

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #12;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_fault", 32'(fetch_fault), 32'd0);
        check("reset_pc", out_pc, 32'd0);
        check("reset_instr", out_instr, 32'd0);
        check("reset_addr", 32'(im_addr), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge clk);
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
            check($sformatf("v%0d_instr", i), out_instr, vecs[i].ei);
            check($sformatf("v%0d_fault", i), 32'(fetch_fault), 32'(vecs[i].ef));
            check($sformatf("v%0d_addr", i), 32'(im_addr), 32'(vecs[i].ea));
            $display("vec %0d: rv=%0b rpc=%08h rdy=%0b -> valid=%0b pc=%08h instr=%08h fault=%0b addr=%03h",
                     i, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, out_valid, out_pc, out_instr, fetch_fault, im_addr);
        end

        // Fill the queue at the top of IM with decode stalled, so it halts holding two entries.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6FF8;
        out_ready      = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("halt_full_valid", 32'(out_valid), 32'd1);
        check("halt_full_pc", out_pc, 32'h6FF8);
        check("halt_full_instr", out_instr, 32'hC000_0FFE);
        check("halt_full_fault", 32'(fetch_fault), 32'd1);
        $display("halt full: valid=%0b pc=%08h fault=%0b", out_valid, out_pc, fetch_fault);

        #1;
        reset = 1'b1;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_fault", 32'(fetch_fault), 32'd0);
        check("async_pc", out_pc, 32'd0);
        check("async_addr", 32'(im_addr), 32'd0);
`ifdef FETCH_PERF_EN
        check("async_perf_fetch", perf_fetch_cnt, 32'd0);
        check("async_perf_stall", perf_stall_cnt, 32'd0);
`endif
        $display("async reset: valid=%0b fault=%0b addr=%03h", out_valid, fetch_fault, im_addr);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("resume_valid", 32'(out_valid), 32'd1);
        check("resume_pc", out_pc, 32'h3000);
        check("resume_instr", out_instr, 32'h1111_1111);
        $display("resume: valid=%0b pc=%08h instr=%08h", out_valid, out_pc, out_instr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
